aer_spike_classifier: RTL and testbench
=======================================

# aer_spike_classifier

Output-side consumer of the SnnAccelerator 8-bit AER bus. Completes the 4-phase AEROUT handshake on every event and counts spikes per output-class neuron during a START/STOP inference window. At STOP it runs a sequential argmax over the class counters and presents the winning class, its count and a tie flag to the inference-all test flow and the future host wrapper. It never stalls the accelerator: every event is acknowledged, including events outside the counting window.

## Interface
Parameters:
- N_CLASSES, 10: neurons 0..N_CLASSES-1 are class neurons; legal range 2..256.
- CNT_W, 8: per-class spike counter width; counters saturate.
- SYNC_STAGES, 2: flip-flop stages on AEROUT_REQ; minimum 2.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- AEROUT_ADDR  in  8  event neuron address; stable while AEROUT_REQ is high.
- AEROUT_REQ  in  1  event request from the accelerator; asynchronous to this block.
- AEROUT_ACK  out  1  event acknowledge; registered.
- START  in  1  one-cycle pulse: clear state and open the counting window.
- STOP  in  1  one-cycle pulse: close the window and start the argmax.
- BUSY  out  1  high in COUNT and ARGMAX.
- RESULT_VALID  out  1  high in DONE.
- RESULT_CLASS  out  $clog2(N_CLASSES)  winning class index.
- RESULT_COUNT  out  CNT_W  spike count of the winning class.
- TIE  out  1  another class equals the winning count.
- TOTAL_SPIKES  out  16  events accepted in the window, all addresses; saturating.

## Operation
Handshake FSM, independent of the main FSM:
- States: H_IDLE, H_ACK.
- H_IDLE: when the synchronized REQ is 1, capture AEROUT_ADDR, set ACK=1 and go to H_ACK.
- H_ACK: when the synchronized REQ is 0, set ACK=0 and go to H_IDLE.
- The address is sampled only at the capture edge.

Main FSM: IDLE, COUNT, ARGMAX, DONE.
- START in any state: clear all class counters, TOTAL_SPIKES, RESULT_* and TIE, then enter COUNT. START has priority over STOP.
- COUNT, on a capture: TOTAL_SPIKES += 1. If addr < N_CLASSES, counter[addr] += 1. Both saturate at all-ones.
- STOP in COUNT enters ARGMAX. A capture on the STOP edge is still counted. STOP in any other state is ignored.
- ARGMAX: one class per cycle, index i = 0..N_CLASSES-1.
  - At i=0, load best = counter[0] and TIE = 0.
  - counter[i] > best: best = counter[i], class = i, TIE = 0.
  - counter[i] == best with i > 0: TIE = 1.
  - Ties therefore resolve to the lowest index.
  - After i = N_CLASSES-1, enter DONE.
- DONE: RESULT_VALID = 1. Results hold until the next START or reset.
- Captures in IDLE, ARGMAX or DONE are acknowledged and dropped. No counter changes.
- All-zero window: RESULT_CLASS=0, RESULT_COUNT=0, TIE=1.

## Timing
- Reset values: AEROUT_ACK=0, BUSY=0, RESULT_VALID=0, RESULT_CLASS=0, RESULT_COUNT=0, TIE=0, TOTAL_SPIKES=0. All counters 0, main FSM in IDLE, handshake in H_IDLE.
- Reset asserted mid-handshake: ACK drops at once. If REQ is still high after reset release, the event is re-acknowledged; it is dropped because the FSM is in IDLE.
- Request latency: REQ rises before edge e. The synchronized REQ is high after edge e+SYNC_STAGES-1. Capture, ACK=1 and the counter increment all take effect at edge e+SYNC_STAGES.
- Release latency: ACK falls SYNC_STAGES edges after REQ falls.
- Throughput: at most one event per 2·SYNC_STAGES+2 cycles.
- START at edge k: counters are cleared and BUSY=1 after edge k. A capture on edge k is discarded.
- STOP at edge k: BUSY stays 1. RESULT_VALID=1 and BUSY=0 after edge k+N_CLASSES.
- START during ARGMAX aborts the argmax. RESULT_VALID stays 0.

## Test plan
- Reset, then 3 events to addr 2, 5 events to addr 7 and 1 to addr 200, then STOP. Expect RESULT_CLASS=7, RESULT_COUNT=5, TIE=0, TOTAL_SPIKES=9, and RESULT_VALID exactly 10 cycles after the STOP edge.
- 4 events each to addr 3 and addr 6, then STOP. Expect RESULT_CLASS=3, RESULT_COUNT=4, TIE=1.
- 300 events to addr 1 with CNT_W=8. Expect RESULT_COUNT=255, TOTAL_SPIKES=300.
- Events before START and after STOP. Every REQ is acknowledged (ACK rises 2 cycles after REQ, falls 2 cycles after REQ falls), and the counts are unchanged.
- RST pulsed while ACK=1 in COUNT. Expect all outputs at reset values immediately, and the held REQ re-acknowledged and not counted.
- START during ARGMAX. Expect counters cleared, BUSY=1, RESULT_VALID=0, and a fresh window counting correctly.

Source files
------------

// File: rtl/aer_spike_classifier.sv
// AER output-bus consumer: acknowledges every event, counts spikes per class
// inside a START/STOP window and runs a sequential argmax at STOP.
module aer_spike_classifier #(
    parameter int N_CLASSES   = 10,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [7:0]                   AEROUT_ADDR,
    input  logic                         AEROUT_REQ,
    output logic                         AEROUT_ACK,
    input  logic                         START,
    input  logic                         STOP,
    output logic                         BUSY,
    output logic                         RESULT_VALID,
    output logic [$clog2(N_CLASSES)-1:0] RESULT_CLASS,
    output logic [CNT_W-1:0]             RESULT_COUNT,
    output logic                         TIE,
    output logic [15:0]                  TOTAL_SPIKES
);

    localparam int IDX_W = $clog2(N_CLASSES);

    typedef enum logic {H_IDLE, H_ACK} hs_state_t;
    typedef enum logic [1:0] {IDLE, COUNT, ARGMAX, DONE} main_state_t;

    logic [SYNC_STAGES-1:0] req_sync_r;
    logic                   req_s;
    logic                   capture_s;
    hs_state_t              hs_state_r;
    logic                   ack_r;

    main_state_t            main_state_r;
    logic [CNT_W-1:0]       cnt_r [N_CLASSES];
    logic [IDX_W-1:0]       idx_r;
    logic [IDX_W-1:0]       class_r;
    logic [CNT_W-1:0]       best_r;
    logic                   tie_r;
    logic                   busy_r;
    logic                   valid_r;
    logic [15:0]            total_r;

    assign req_s     = req_sync_r[SYNC_STAGES-1];
    // The address is taken straight off the bus on the capture edge; it is stable while REQ is high.
    assign capture_s = (hs_state_r == H_IDLE) && req_s;

    // REQ comes from another clock domain: plain flop chain synchronizer.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            req_sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            req_sync_r <= {req_sync_r[SYNC_STAGES-2:0], AEROUT_REQ};
        end
    end

    // Four-phase handshake; runs regardless of the main FSM so the producer never stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hs_state_r <= H_IDLE;
            ack_r      <= 1'b0;
        end else begin
            case (hs_state_r)
                H_IDLE: begin
                    if (req_s) begin
                        ack_r      <= 1'b1;
                        hs_state_r <= H_ACK;
                    end
                end
                H_ACK: begin
                    if (!req_s) begin
                        ack_r      <= 1'b0;
                        hs_state_r <= H_IDLE;
                    end
                end
                default: begin
                    ack_r      <= 1'b0;
                    hs_state_r <= H_IDLE;
                end
            endcase
        end
    end

    // Main window / argmax FSM, class counters and result registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            main_state_r <= IDLE;
            for (int i = 0; i < N_CLASSES; i++) cnt_r[i] <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            class_r <= {IDX_W{1'b0}};
            best_r  <= {CNT_W{1'b0}};
            tie_r   <= 1'b0;
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            total_r <= 16'd0;
        end else if (START) begin
            // START wins over STOP and over any capture on the same edge.
            main_state_r <= COUNT;
            for (int i = 0; i < N_CLASSES; i++) cnt_r[i] <= {CNT_W{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            class_r <= {IDX_W{1'b0}};
            best_r  <= {CNT_W{1'b0}};
            tie_r   <= 1'b0;
            busy_r  <= 1'b1;
            valid_r <= 1'b0;
            total_r <= 16'd0;
        end else begin
            case (main_state_r)
                COUNT: begin
                    if (capture_s) begin
                        if (total_r != 16'hFFFF) total_r <= total_r + 16'd1;
                        for (int i = 0; i < N_CLASSES; i++) begin
                            if ((AEROUT_ADDR == 8'(i)) && (cnt_r[i] != {CNT_W{1'b1}})) begin
                                cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
                            end
                        end
                    end
                    if (STOP) begin
                        main_state_r <= ARGMAX;
                        idx_r        <= {IDX_W{1'b0}};
                    end
                end
                ARGMAX: begin
                    if (idx_r == {IDX_W{1'b0}}) begin
                        best_r  <= cnt_r[0];
                        class_r <= {IDX_W{1'b0}};
                        tie_r   <= 1'b0;
                    end else if (cnt_r[idx_r] > best_r) begin
                        best_r  <= cnt_r[idx_r];
                        class_r <= idx_r;
                        tie_r   <= 1'b0;
                    end else if (cnt_r[idx_r] == best_r) begin
                        tie_r   <= 1'b1;
                    end
                    if (idx_r == IDX_W'(N_CLASSES - 1)) begin
                        main_state_r <= DONE;
                        busy_r       <= 1'b0;
                        valid_r      <= 1'b1;
                    end else begin
                        idx_r <= idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                IDLE, DONE: begin
                    main_state_r <= main_state_r;
                end
                default: begin
                    main_state_r <= IDLE;
                    busy_r       <= 1'b0;
                    valid_r      <= 1'b0;
                end
            endcase
        end
    end

    assign AEROUT_ACK   = ack_r;
    assign BUSY         = busy_r;
    assign RESULT_VALID = valid_r;
    assign RESULT_CLASS = class_r;
    assign RESULT_COUNT = best_r;
    assign TIE          = tie_r;
    assign TOTAL_SPIKES = total_r;

endmodule

// File: tb/tb_aer_spike_classifier.sv
// Randomized self-checking bench for aer_spike_classifier against a
// spike-count / argmax reference model.
module tb_aer_spike_classifier;

    localparam int N_CLASSES   = 10;
    localparam int CNT_W       = 8;
    localparam int SYNC_STAGES = 2;
    // Edges counted from the first edge that sees the REQ change until ACK follows.
    localparam int ACK_LAT     = SYNC_STAGES + 1;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic                         CLK = 1'b0;
    logic                         RST;
    logic [7:0]                   AEROUT_ADDR;
    logic                         AEROUT_REQ;
    logic                         AEROUT_ACK;
    logic                         START;
    logic                         STOP;
    logic                         BUSY;
    logic                         RESULT_VALID;
    logic [$clog2(N_CLASSES)-1:0] RESULT_CLASS;
    logic [CNT_W-1:0]             RESULT_COUNT;
    logic                         TIE;
    logic [15:0]                  TOTAL_SPIKES;

    aer_spike_classifier #(
        .N_CLASSES(N_CLASSES), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK(CLK), .RST(RST), .AEROUT_ADDR(AEROUT_ADDR), .AEROUT_REQ(AEROUT_REQ),
        .AEROUT_ACK(AEROUT_ACK), .START(START), .STOP(STOP), .BUSY(BUSY),
        .RESULT_VALID(RESULT_VALID), .RESULT_CLASS(RESULT_CLASS),
        .RESULT_COUNT(RESULT_COUNT), .TIE(TIE), .TOTAL_SPIKES(TOTAL_SPIKES)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: raw event counts per address and a window-open flag.
    int mdl_cnt [256];
    int mdl_total;
    bit mdl_open;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) mdl_cnt[i] = 0;
        mdl_total = 0;
    endtask

    task automatic wait_ack(input logic lvl, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (AEROUT_ACK !== lvl && n < 50);
    endtask

    task automatic send_event(input logic [7:0] a);
        int n;
        AEROUT_ADDR = a;
        AEROUT_REQ  = 1'b1;
        wait_ack(1'b1, n);
        check_val("ack_rise_latency", n, ACK_LAT);
        if (mdl_open) begin
            mdl_cnt[a]++;
            mdl_total++;
        end
        check_val("total_live", TOTAL_SPIKES, (mdl_total > 65535) ? 65535 : mdl_total);
        AEROUT_REQ = 1'b0;
        wait_ack(1'b0, n);
        check_val("ack_fall_latency", n, ACK_LAT);
        AEROUT_ADDR = 8'($urandom);
        repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic start_window();
        START = 1'b1;
        tick();
        START = 1'b0;
        model_clear();
        mdl_open = 1'b1;
        check_val("start_busy", BUSY, 1);
        check_val("start_valid", RESULT_VALID, 0);
        check_val("start_total", TOTAL_SPIKES, 0);
        check_val("start_count", RESULT_COUNT, 0);
        check_val("start_tie", TIE, 0);
    endtask

    // Expected result straight from the counts: max saturated count, lowest index holding it.
    task automatic check_results(input string tag);
        int best, cls, n_best, c;
        best = -1; cls = 0; n_best = 0;
        for (int i = 0; i < N_CLASSES; i++) begin
            c = (mdl_cnt[i] > CNT_MAX) ? CNT_MAX : mdl_cnt[i];
            if (c > best) begin
                best = c; cls = i; n_best = 1;
            end else if (c == best) begin
                n_best++;
            end
        end
        check_val({tag, "_valid"}, RESULT_VALID, 1);
        check_val({tag, "_busy"}, BUSY, 0);
        check_val({tag, "_class"}, RESULT_CLASS, cls);
        check_val({tag, "_count"}, RESULT_COUNT, best);
        check_val({tag, "_tie"}, TIE, (n_best > 1) ? 1 : 0);
        check_val({tag, "_total"}, TOTAL_SPIKES, (mdl_total > 65535) ? 65535 : mdl_total);
    endtask

    task automatic pulse_stop();
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        mdl_open = 1'b0;
        check_val("stop_busy", BUSY, 1);
    endtask

    task automatic stop_and_check(input string tag);
        int n;
        pulse_stop();
        n = 0;
        while (RESULT_VALID !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check_val({tag, "_valid_latency"}, n, N_CLASSES);
        check_results(tag);
    endtask

    task automatic send_shuffled(input int a0, input int n0, input int a1, input int n1, input int a2, input int n2);
        logic [7:0] q [$];
        logic [7:0] t;
        int j;
        repeat (n0) q.push_back(8'(a0));
        repeat (n1) q.push_back(8'(a1));
        repeat (n2) q.push_back(8'(a2));
        for (int i = q.size() - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = q[i]; q[i] = q[j]; q[j] = t;
        end
        foreach (q[i]) send_event(q[i]);
    endtask

    initial begin
        int n;
        RST = 1'b1; AEROUT_ADDR = 8'd0; AEROUT_REQ = 1'b0; START = 1'b0; STOP = 1'b0;
        mdl_open = 1'b0;
        model_clear();
        tick();
        tick();
        RST = 1'b0;
        tick();

        check_val("rst_ack", AEROUT_ACK, 0);
        check_val("rst_busy", BUSY, 0);
        check_val("rst_valid", RESULT_VALID, 0);
        check_val("rst_class", RESULT_CLASS, 0);
        check_val("rst_count", RESULT_COUNT, 0);
        check_val("rst_tie", TIE, 0);
        check_val("rst_total", TOTAL_SPIKES, 0);

        // Events before any START are acknowledged but not counted.
        repeat (3) send_event(8'($urandom_range(0, 9)));
        check_val("pre_start_total", TOTAL_SPIKES, 0);

        start_window();
        send_shuffled(2, 3, 7, 5, 200, 1);
        stop_and_check("basic");

        // Events after STOP leave the held results untouched.
        repeat (3) send_event(8'($urandom_range(0, 9)));
        check_results("post_stop");

        start_window();
        send_shuffled(3, 4, 6, 4, 0, 0);
        stop_and_check("tie");

        start_window();
        stop_and_check("zero");

        start_window();
        repeat (300) send_event(8'd1);
        stop_and_check("saturate");

        for (int w = 0; w < 3; w++) begin
            start_window();
            repeat ($urandom_range(0, 25)) send_event(8'($urandom_range(0, 15)));
            stop_and_check("random");
        end

        // Reset while ACK is high in COUNT.
        start_window();
        send_event(8'd4);
        AEROUT_ADDR = 8'd5;
        AEROUT_REQ  = 1'b1;
        wait_ack(1'b1, n);
        check_val("pre_rst_ack", n, ACK_LAT);
        #2 RST = 1'b1;
        #1;
        check_val("async_rst_ack", AEROUT_ACK, 0);
        check_val("async_rst_busy", BUSY, 0);
        check_val("async_rst_total", TOTAL_SPIKES, 0);
        check_val("async_rst_valid", RESULT_VALID, 0);
        check_val("async_rst_count", RESULT_COUNT, 0);
        tick();
        RST = 1'b0;
        mdl_open = 1'b0;
        model_clear();
        wait_ack(1'b1, n);
        check_val("reack_latency", n, ACK_LAT);
        check_val("reack_total", TOTAL_SPIKES, 0);
        check_val("reack_busy", BUSY, 0);
        AEROUT_REQ = 1'b0;
        wait_ack(1'b0, n);
        check_val("reack_release", n, ACK_LAT);

        // START during ARGMAX aborts it and opens a clean window.
        start_window();
        repeat (6) send_event(8'($urandom_range(0, 9)));
        pulse_stop();
        repeat (3) tick();
        check_val("mid_argmax_valid", RESULT_VALID, 0);
        start_window();
        repeat (3) tick();
        check_val("abort_valid", RESULT_VALID, 0);
        repeat (8) send_event(8'($urandom_range(0, 12)));
        stop_and_check("after_abort");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
